clk_div_multi: RTL and testbench

- Multi-channel programmable clock/tick divider; next generation of the fixed-ratio toggle divider.
- CHANNELS independent outputs, each with:
  - a runtime-writable period (in i_clk cycles);
  - a per-channel enable;
  - a near-50% duty clock output;
  - a one-cycle period-start tick.
- Sits between the system clock and the display scan, cell-update and UART timing logic. The clock outputs are used as clock enables or low-speed clocks.

---
 rtl/clk_div_multi.sv | 132 +++++++++++++
 tb/tb_clk_div_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick divider with glitch-free ratio updates at period boundaries.
// Optional CLKDIV_SYNC_EN adds i_sync to phase-align every enabled channel.

module clk_div_lane #(
    parameter int CNT_W       = 16,
    parameter int RESET_RATIO = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_ratio,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_pend
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] RR  = CNT_W'(RESET_RATIO);

    logic [CNT_W-1:0] cnt, act_r, pend_r;
    logic [CNT_W-1:0] cnt_n, act_n, pend_r_n;
    logic             pend_v, pend_v_n;

    always_comb begin
        cnt_n    = cnt;
        act_n    = act_r;
        pend_r_n = pend_r;
        pend_v_n = pend_v;
        if (!en) begin
            // parked one short of the boundary so the first enabled edge starts a period
            act_n    = pend_v ? pend_r : act_r;
            pend_v_n = 1'b0;
            cnt_n    = act_n - ONE;
        end else if (sync) begin
            act_n    = wr ? wr_ratio : (pend_v ? pend_r : act_r);
            pend_v_n = 1'b0;
            cnt_n    = '0;
        end else if (cnt >= act_r - ONE) begin
            cnt_n = '0;
            if (pend_v) begin
                act_n    = pend_r;
                pend_v_n = 1'b0;
            end
        end else begin
            cnt_n = cnt + ONE;
        end
        // a write on a boundary edge lands after the old pending value was consumed
        if (wr) pend_r_n = wr_ratio;
        if (wr && !(en && sync)) pend_v_n = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt    <= RR - ONE;
            act_r  <= RR;
            pend_r <= RR;
            pend_v <= 1'b0;
            o_clk  <= 1'b0;
            o_tick <= 1'b0;
        end else begin
            cnt    <= cnt_n;
            act_r  <= act_n;
            pend_r <= pend_r_n;
            pend_v <= pend_v_n;
            o_tick <= en && (cnt_n == '0);
            o_clk  <= en && (cnt_n < act_n - (act_n >> 1));
        end
    end

    assign o_pend = pend_v;

endmodule

module clk_div_multi #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 16,
    parameter int RESET_RATIO = 16,
    localparam int WCH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
`ifdef CLKDIV_SYNC_EN
    input  logic                i_sync,
`endif
    input  logic [CHANNELS-1:0] i_en,
    input  logic                i_wr,
    input  logic [WCH_W-1:0]    i_wr_ch,
    input  logic [CNT_W-1:0]    i_wr_ratio,
    output logic [CHANNELS-1:0] o_clk,
    output logic [CHANNELS-1:0] o_tick,
    output logic [CHANNELS-1:0] o_pend
);

    logic                sync;
    logic [CNT_W-1:0]    wr_ratio_c;
    logic [CHANNELS-1:0] wr_hit;

`ifdef CLKDIV_SYNC_EN
    assign sync = i_sync;
`else
    assign sync = 1'b0;
`endif

    // ratios below 2 cannot produce both a high and a low phase
    assign wr_ratio_c = (i_wr_ratio < CNT_W'(2)) ? CNT_W'(2) : i_wr_ratio;

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            // out-of-range channel numbers never match any lane
            assign wr_hit[g] = i_wr && (i_wr_ch == WCH_W'(g));

            clk_div_lane #(
                .CNT_W      (CNT_W),
                .RESET_RATIO(RESET_RATIO)
            ) u_lane (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .en      (i_en[g]),
                .sync    (sync),
                .wr      (wr_hit[g]),
                .wr_ratio(wr_ratio_c),
                .o_clk   (o_clk[g]),
                .o_tick  (o_tick[g]),
                .o_pend  (o_pend[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomized self-checking bench for clk_div_multi against a cycle-level period/phase model.
// A 3-channel copy shares the stimulus so writes to channel 3 exercise the out-of-range ignore path.

module tb_clk_div_multi;

    logic        i_clk;
    logic        i_rst_n;
    logic [3:0]  i_en;
    logic        i_wr;
    logic [1:0]  i_wr_ch;
    logic [15:0] i_wr_ratio;
    logic [3:0]  o_clk, o_tick, o_pend;
    logic [2:0]  o3_clk, o3_tick, o3_pend;
`ifdef CLKDIV_SYNC_EN
    logic        i_sync;
`endif

    int total = 0;
    int bad   = 0;

    // model: position within current period, active period, pending period
    int   pos [4];
    int   per [4];
    int   pnd [4];
    bit   pv  [4];
    logic [3:0] m_clk, m_tick, m_pend;

    clk_div_multi #(.CHANNELS(4), .CNT_W(16), .RESET_RATIO(16)) u_dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
`ifdef CLKDIV_SYNC_EN
        .i_sync    (i_sync),
`endif
        .i_en      (i_en),
        .i_wr      (i_wr),
        .i_wr_ch   (i_wr_ch),
        .i_wr_ratio(i_wr_ratio),
        .o_clk     (o_clk),
        .o_tick    (o_tick),
        .o_pend    (o_pend)
    );

    clk_div_multi #(.CHANNELS(3), .CNT_W(16), .RESET_RATIO(16)) u_dut3 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
`ifdef CLKDIV_SYNC_EN
        .i_sync    (i_sync),
`endif
        .i_en      (i_en[2:0]),
        .i_wr      (i_wr),
        .i_wr_ch   (i_wr_ch),
        .i_wr_ratio(i_wr_ratio),
        .o_clk     (o3_clk),
        .o_tick    (o3_tick),
        .o_pend    (o3_pend)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            per[c] = 16;
            pos[c] = 15;
            pnd[c] = 16;
            pv[c]  = 1'b0;
        end
        m_clk  = '0;
        m_tick = '0;
        m_pend = '0;
    endfunction

    function automatic void model_step(logic [3:0] en, logic wr, logic [1:0] ch,
                                       logic [15:0] r, logic sy);
        bit hit;
        int cr;
        cr = (r < 16'd2) ? 2 : int'(r);
        for (int c = 0; c < 4; c++) begin
            hit = wr && (int'(ch) == c);
            if (!en[c]) begin
                if (pv[c]) begin per[c] = pnd[c]; pv[c] = 1'b0; end
                pos[c] = per[c] - 1;
            end else if (sy) begin
                per[c] = hit ? cr : (pv[c] ? pnd[c] : per[c]);
                pv[c]  = 1'b0;
                pos[c] = 0;
            end else if (pos[c] == per[c] - 1) begin
                pos[c] = 0;
                if (pv[c]) begin per[c] = pnd[c]; pv[c] = 1'b0; end
            end else begin
                pos[c] = pos[c] + 1;
            end
            if (hit && !(en[c] && sy)) begin pnd[c] = cr; pv[c] = 1'b1; end
            m_tick[c] = en[c] && (pos[c] == 0);
            m_clk[c]  = en[c] && (pos[c] < (per[c] + 1) / 2);
            m_pend[c] = pv[c];
        end
    endfunction

    task automatic cycle(input logic [3:0] en, input logic wr, input logic [1:0] ch,
                         input logic [15:0] r, input logic sy);
        i_en = en; i_wr = wr; i_wr_ch = ch; i_wr_ratio = r;
`ifdef CLKDIV_SYNC_EN
        i_sync = sy;
`endif
        @(posedge i_clk);
        model_step(en, wr, ch, r, sy);
        #1;
        chk("clk",   o_clk,   m_clk);
        chk("tick",  o_tick,  m_tick);
        chk("pend",  o_pend,  m_pend);
        chk("clk3",  o3_clk,  m_clk[2:0]);
        chk("tick3", o3_tick, m_tick[2:0]);
        chk("pend3", o3_pend, m_pend[2:0]);
        i_wr = 1'b0;
`ifdef CLKDIV_SYNC_EN
        i_sync = 1'b0;
`endif
    endtask

    task automatic idle(input logic [3:0] en, input int n);
        for (int k = 0; k < n; k++) cycle(en, 1'b0, 2'd0, 16'd0, 1'b0);
    endtask

    task automatic check_all_low(input string tag);
        chk({tag, "_clk"},  {o3_clk,  o_clk},  '0);
        chk({tag, "_tick"}, {o3_tick, o_tick}, '0);
        chk({tag, "_pend"}, {o3_pend, o_pend}, '0);
    endtask

    initial begin
        int t0, t1, hi, n;
        logic [3:0] en;
        i_rst_n = 1'b0; i_en = '0; i_wr = 1'b0; i_wr_ch = '0; i_wr_ratio = '0;
`ifdef CLKDIV_SYNC_EN
        i_sync = 1'b0;
`endif
        model_reset();
        #20;
        check_all_low("rst");
        #2 i_rst_n = 1'b1;

        // ch0 alone at reset ratio: first tick on first enabled edge, period 16, 8 high
        t0 = -1; t1 = -1; hi = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(4'b0001, 1'b0, 2'd0, 16'd0, 1'b0);
            if (k < 16 && o_clk[0]) hi++;
            if (o_tick[0]) begin
                if (t0 < 0) t0 = k;
                else if (t1 < 0) t1 = k;
            end
        end
        chk("first_tick", t0, 0);
        chk("period16", t1 - t0, 16);
        chk("high8", hi, 8);

        // ch1 write mid-period
        idle(4'b0011, 7);
        cycle(4'b0011, 1'b1, 2'd1, 16'd5, 1'b0);
        chk("pend1_set", o_pend[1], 1'b1);
        idle(4'b0011, 30);

        // ch0 write on its boundary edge waits one more full period
        n = 0;
        while (pos[0] != per[0] - 1 && n < 64) begin
            idle(4'b0011, 1);
            n++;
        end
        chk("wait_bnd0", n < 64, 1'b1);
        cycle(4'b0011, 1'b1, 2'd0, 16'd7, 1'b0);
        chk("bnd_wr_pend", o_pend[0], 1'b1);
        idle(4'b0011, 40);

        // clamp of 0 and 1 on ch2; ch3 writes only reach the 4-channel copy
        cycle(4'b0111, 1'b1, 2'd2, 16'd0, 1'b0);
        idle(4'b0111, 20);
        cycle(4'b0111, 1'b1, 2'd2, 16'd1, 1'b0);
        idle(4'b0111, 20);
        cycle(4'b0111, 1'b1, 2'd3, 16'd9, 1'b0);
        chk("ign_pend3", o3_pend, 3'b000);
        idle(4'b0111, 6);

        // enable drop mid-period, write while disabled, re-enable
        cycle(4'b0111, 1'b1, 2'd0, 16'd10, 1'b0);
        n = 0;
        while ((pv[0] || pos[0] != 3) && n < 64) begin
            idle(4'b0111, 1);
            n++;
        end
        chk("wait_cnt3", n < 64, 1'b1);
        cycle(4'b0110, 1'b0, 2'd0, 16'd0, 1'b0);
        chk("drop_low", o_clk[0], 1'b0);
        cycle(4'b0110, 1'b1, 2'd0, 16'd4, 1'b0);
        idle(4'b0110, 3);
        cycle(4'b0111, 1'b0, 2'd0, 16'd0, 1'b0);
        chk("reen_tick", o_tick[0], 1'b1);
        idle(4'b0111, 12);

`ifdef CLKDIV_SYNC_EN
        cycle(4'b0011, 1'b1, 2'd0, 16'd6, 1'b0);
        cycle(4'b0011, 1'b1, 2'd1, 16'd9, 1'b0);
        idle(4'b0011, 40);
        cycle(4'b0011, 1'b0, 2'd0, 16'd0, 1'b1);
        chk("sync_tick", o_tick[1:0], 2'b11);
        n = 0;
        do begin
            idle(4'b0011, 1);
            n++;
        end while (o_tick[1:0] != 2'b11 && n < 40);
        chk("sync_gap", n, 18);
`endif

        // randomized traffic
        en = 4'b1011;
        for (int k = 0; k < 800; k++) begin
            logic sy;
            if ($urandom_range(0, 15) == 0) en[$urandom_range(0, 3)] ^= 1'b1;
            sy = 1'b0;
`ifdef CLKDIV_SYNC_EN
            sy = ($urandom_range(0, 24) == 0);
`endif
            cycle(en, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                  16'($urandom_range(0, 12)), sy);
        end

        // async reset mid-period, no clock edge in between
        idle(4'b1111, 5);
        #2 i_rst_n = 1'b0;
        #1 check_all_low("arst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        model_reset();
        idle(4'b1010, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
